// File: rtl/soc_eoc_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_eoc_responder_if
// Purpose  : soc/eoc handshake plus host FIFO write port of the responder.
// Revision : 1.0
// ============================================================================
interface soc_eoc_responder_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          soc;
    logic          eoc;
    logic [W-1:0]  x;
    logic          wr;
    logic [W-1:0]  din;
    logic          full;
    logic [LW-1:0] level;

    modport master (output soc, wr, din, input eoc, x, full, level);
    modport slave  (input soc, wr, din, output eoc, x, full, level);
endinterface
`default_nettype wire

// File: rtl/soc_eoc_responder.sv
`default_nettype none
// ============================================================================
// Module   : soc_eoc_responder
// Purpose  : Converter-side soc/eoc responder serving preloaded FIFO samples.
// Revision : 1.0
// ============================================================================
module soc_eoc_responder #(
    parameter int W            = 8,
    parameter int DEPTH        = 4,
    parameter int ACK_CYCLES   = 1,
    parameter int CONV_CYCLES  = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    soc_eoc_responder_if.slave    bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAXA = (ACK_CYCLES > CONV_CYCLES) ? ACK_CYCLES : CONV_CYCLES;
    localparam int MAXC = (MAXA > SETUP_CYCLES) ? MAXA : SETUP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_ack      = 3'd1;
    localparam logic [2:0] c_wait_low = 3'd2;
    localparam logic [2:0] c_conv     = 3'd3;
    localparam logic [2:0] c_setup    = 3'd4;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_eoc;
    logic [W-1:0]  r_x;

    logic w_full;
    logic w_wr;
    logic w_pop;

    assign w_full = (r_level == LW'(DEPTH));
    assign w_wr   = bus.wr && !w_full;
    // Pop uses the registered level, so a same-edge write is never popped.
    assign w_pop  = (r_state == c_conv) && (r_cnt == '0) && (r_level != '0);

    assign bus.eoc   = r_eoc;
    assign bus.x     = r_x;
    assign bus.full  = w_full;
    assign bus.level = r_level;

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr] <= bus.din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_eoc   <= 1'b1;
            r_x     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.soc) begin
                        r_state <= c_ack;
                        r_cnt   <= CW'(ACK_CYCLES - 1);
                    end
                end
                c_ack: begin
                    if (r_cnt == '0) begin
                        r_eoc   <= 1'b0;
                        r_state <= c_wait_low;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_wait_low: begin
                    if (!bus.soc) begin
                        r_state <= c_conv;
                        r_cnt   <= CW'(CONV_CYCLES - 1);
                    end
                end
                c_conv: begin
                    // Once expired the counter parks at zero until data arrives.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_pop) begin
                        r_x     <= r_mem[r_rptr];
                        r_state <= c_setup;
                        r_cnt   <= CW'(SETUP_CYCLES - 1);
                    end
                end
                c_setup: begin
                    if (r_cnt == '0) begin
                        r_eoc   <= 1'b1;
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_eoc   <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_soc_eoc_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_eoc_responder
// Purpose  : Directed bench for soc_eoc_responder (default and slow timing).
// Revision : 1.0
// ============================================================================
module tb_soc_eoc_responder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] exp_q [$];

    soc_eoc_responder_if #(.W(8), .DEPTH(4)) bus0 ();
    soc_eoc_responder_if #(.W(8), .DEPTH(4)) bus1 ();

    soc_eoc_responder #(.W(8), .DEPTH(4)) dut0 (
        .clock (clk),
        .reset (rst),
        .bus   (bus0.slave)
    );

    soc_eoc_responder #(
        .W(8), .DEPTH(4), .ACK_CYCLES(2), .CONV_CYCLES(4), .SETUP_CYCLES(3)
    ) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input logic [7:0] v);
        bus0.wr  = 1'b1;
        bus0.din = v;
        step(1);
        bus0.wr  = 1'b0;
        exp_q.push_back(v);
    endtask

    // Full handshake on dut0; expects eoc to fall, then rise with exp_x on x.
    task automatic conv0(input string tag, input logic [7:0] exp_x);
        int n;
        bus0.soc = 1'b1;
        n = 0;
        while (bus0.eoc !== 1'b0 && n < 50) begin
            step(1);
            n++;
        end
        check({tag, "_eoc_lo"}, 32'(bus0.eoc), 32'd0);
        bus0.soc = 1'b0;
        n = 0;
        while (bus0.eoc !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        check({tag, "_eoc_hi"}, 32'(bus0.eoc), 32'd1);
        check({tag, "_x"}, 32'(bus0.x), 32'(exp_x));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus0.soc = 1'b0; bus0.wr = 1'b0; bus0.din = '0;
        bus1.soc = 1'b0; bus1.wr = 1'b0; bus1.din = '0;
        step(2);
        rst = 1'b0;
        check("rst_eoc",   32'(bus0.eoc),   32'd1);
        check("rst_x",     32'(bus0.x),     32'd0);
        check("rst_level", 32'(bus0.level), 32'd0);
        check("rst_full",  32'(bus0.full),  32'd0);

        // Reset asserted while the responder sits in CONV.
        push0(8'h55);
        void'(exp_q.pop_front());
        bus0.soc = 1'b1;
        step(2);
        bus0.soc = 1'b0;
        step(1);
        check("midconv_eoc", 32'(bus0.eoc), 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mrst_eoc",   32'(bus0.eoc),   32'd1);
        check("mrst_x",     32'(bus0.x),     32'd0);
        check("mrst_level", 32'(bus0.level), 32'd0);
        check("mrst_full",  32'(bus0.full),  32'd0);

        // Single conversion with exact edge timing: soc sampled high at k..k+2.
        push0(8'd40);
        void'(exp_q.pop_front());
        bus0.soc = 1'b1;
        step(1);
        check("t_k_eoc", 32'(bus0.eoc), 32'd1);
        step(1);
        check("t_k1_eoc", 32'(bus0.eoc), 32'd0);
        step(1);
        bus0.soc = 1'b0;
        step(2);
        check("t_k4_x", 32'(bus0.x), 32'd0);
        step(1);
        check("t_k5_x",   32'(bus0.x),   32'd40);
        check("t_k5_eoc", 32'(bus0.eoc), 32'd0);
        step(1);
        check("t_k6_eoc",   32'(bus0.eoc),   32'd1);
        check("t_k6_level", 32'(bus0.level), 32'd0);

        // Fill to full, drop a fifth write, then drain in order.
        push0(8'h00);
        push0(8'h80);
        push0(8'hD8);
        push0(8'h40);
        check("fill_level", 32'(bus0.level), 32'd4);
        check("fill_full",  32'(bus0.full),  32'd1);
        bus0.wr = 1'b1; bus0.din = 8'h11;
        step(1);
        bus0.wr = 1'b0;
        check("drop_level", 32'(bus0.level), 32'd4);
        conv0("drain0", 8'h00);
        check("drain0_full",  32'(bus0.full),  32'd0);
        check("drain0_level", 32'(bus0.level), 32'd3);
        conv0("drain1", 8'h80);
        conv0("drain2", 8'hD8);
        conv0("drain3", 8'h40);
        exp_q.delete();

        // Empty FIFO at CONV expiry: stall until a write lands.
        bus0.soc = 1'b1;
        step(2);
        bus0.soc = 1'b0;
        step(3);
        step(5);
        check("stall_eoc", 32'(bus0.eoc), 32'd0);
        check("stall_x",   32'(bus0.x),   32'h40);
        bus0.wr = 1'b1; bus0.din = 8'hCE;
        step(1);
        bus0.wr = 1'b0;
        check("stall_wr_x", 32'(bus0.x), 32'h40);
        step(1);
        check("stall_pop_x",   32'(bus0.x),   32'hCE);
        check("stall_pop_eoc", 32'(bus0.eoc), 32'd0);
        step(1);
        check("stall_eoc_hi", 32'(bus0.eoc), 32'd1);

        // Write coinciding with a pop at level 2.
        push0(8'h01);
        push0(8'h02);
        bus0.soc = 1'b1;
        step(2);
        bus0.soc = 1'b0;
        step(2);
        bus0.wr = 1'b1; bus0.din = 8'h03;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h03);
        step(1);
        bus0.wr = 1'b0;
        check("wp_level", 32'(bus0.level), 32'd2);
        check("wp_x",     32'(bus0.x),     32'h01);
        step(1);
        conv0("wp_d0", exp_q.pop_front());
        conv0("wp_d1", exp_q.pop_front());

        // 32 back-to-back conversions wrapping the pointers.
        push0(8'd5);
        push0(8'd42);
        for (int i = 0; i < 32; i++) begin
            if (i < 30) push0(8'((i + 2) * 37 + 5));
            conv0("b2b", exp_q.pop_front());
        end
        check("b2b_level", 32'(bus0.level), 32'd0);

        // Slow timing instance: ACK=2, CONV=4, SETUP=3.
        bus1.wr = 1'b1; bus1.din = 8'h5A;
        step(1);
        bus1.wr = 1'b0;
        bus1.soc = 1'b1;
        step(1);
        n = 0;
        while (bus1.eoc === 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("p_ack_dist", 32'(n), 32'd2);
        bus1.soc = 1'b0;
        step(1);
        n = 0;
        while (bus1.x !== 8'h5A && n < 20) begin
            step(1);
            n++;
        end
        check("p_conv_dist", 32'(n), 32'd4);
        check("p_conv_eoc",  32'(bus1.eoc), 32'd0);
        n = 0;
        while (bus1.eoc !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("p_setup_dist", 32'(n), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
